// File: rtl/systolic_pe_mac_if.sv
// Operand/result bundle between a systolic PE and its driver; master feeds operands, slave is the PE.
// ACC_W must match the PE instance it is bound to.
interface systolic_pe_mac_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic [3:0]       a_in;
    logic [3:0]       b_in;
    logic             clear;
    logic [3:0]       a_out;
    logic [3:0]       b_out;
    logic             out_valid;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ovf;

    modport master (
        output in_valid, a_in, b_in, clear,
        input  a_out, b_out, out_valid, acc_out, acc_valid, acc_ovf
    );

    modport slave (
        input  in_valid, a_in, b_in, clear,
        output a_out, b_out, out_valid, acc_out, acc_valid, acc_ovf
    );
endinterface

// File: rtl/systolic_pe_mac.sv
// Systolic PE: forwards a/b with 1-cycle latency, MACs K_LEN valid products per result (valid+3 cycles).
// No backpressure: every cycle is consumed. Define PE_SAT_EN for saturating accumulation with sticky acc_ovf.
module vedic_mul2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic x10, x01, x11, c1;
    assign x10  = a[1] & b[0];
    assign x01  = a[0] & b[1];
    assign x11  = a[1] & b[1];
    assign c1   = x10 & x01;
    assign p[0] = a[0] & b[0];
    assign p[1] = x10 ^ x01;
    assign p[2] = x11 ^ c1;
    assign p[3] = x11 & c1;
endmodule

module vedic_multu4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;

    vedic_mul2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_mul2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_mul2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_mul2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    // Cross terms share weight 4; the 2x2 partials are recombined by shifted addition.
    assign p = {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
endmodule

module systolic_pe_mac #(
    parameter int ACC_W = 16,
    parameter int K_LEN = 9
) (
    input  logic            clk,
    input  logic            rst,
    systolic_pe_mac_if.slave pe
);
    localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K_LEN - 1);

    logic [3:0]       a_q, b_q;
    logic             v_q, m_v;
    logic [7:0]       p, p_q;
    logic             pv_q;
    logic [ACC_W-1:0] acc, acc_res, acc_out_q;
    logic [CNT_W-1:0] count;
    logic             acc_valid_q;

    vedic_multu4 u_mul (.a(a_q), .b(b_q), .p(p));

`ifdef PE_SAT_EN
    localparam int SUM_W = ACC_W + 1;
    logic [ACC_W:0] sum_w;
    logic           ovf_hit, ovf_q;

    always_comb begin
        sum_w   = {1'b0, acc} + SUM_W'(p_q);
        ovf_hit = sum_w[ACC_W];
        acc_res = ovf_hit ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (pv_q && !pe.clear && ovf_hit)
            ovf_q <= 1'b1;
    end

    assign pe.acc_ovf = ovf_q;
`else
    always_comb begin
        acc_res = acc + ACC_W'(p_q);
    end

    assign pe.acc_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            v_q         <= 1'b0;
            m_v         <= 1'b0;
            p_q         <= '0;
            pv_q        <= 1'b0;
            acc         <= '0;
            count       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            a_q         <= pe.a_in;
            b_q         <= pe.b_in;
            v_q         <= pe.in_valid;
            m_v         <= pe.in_valid;
            p_q         <= p;
            pv_q        <= m_v & ~pe.clear;
            acc_valid_q <= 1'b0;
            // clear also kills the product in pv_q, so it wins over a completing window.
            if (pe.clear) begin
                acc   <= '0;
                count <= '0;
            end else if (pv_q) begin
                if (count == LAST) begin
                    acc_out_q   <= acc_res;
                    acc_valid_q <= 1'b1;
                    acc         <= '0;
                    count       <= '0;
                end else begin
                    acc   <= acc_res;
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign pe.a_out     = a_q;
    assign pe.b_out     = b_q;
    assign pe.out_valid = v_q;
    assign pe.acc_out   = acc_out_q;
    assign pe.acc_valid = acc_valid_q;
endmodule

// File: tb/tb_systolic_pe_mac.sv
// Directed bench for systolic_pe_mac: main PE (ACC_W=16,K_LEN=9), narrow PE (ACC_W=10) and K_LEN=1 PE.
module tb_systolic_pe_mac;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_pe_mac_if #(.ACC_W(16)) bus ();
    systolic_pe_mac_if #(.ACC_W(10)) bus_o ();
    systolic_pe_mac_if #(.ACC_W(16)) bus_k1 ();

    systolic_pe_mac #(.ACC_W(16), .K_LEN(9)) dut    (.clk(clk), .rst(rst), .pe(bus.slave));
    systolic_pe_mac #(.ACC_W(10), .K_LEN(9)) dut_o  (.clk(clk), .rst(rst), .pe(bus_o.slave));
    systolic_pe_mac #(.ACC_W(16), .K_LEN(1)) dut_k1 (.clk(clk), .rst(rst), .pe(bus_k1.slave));

    int res_q[$], res_t[$], o_q[$], k1_q[$], k1_t[$];

    always @(negedge clk) begin
        if (bus.acc_valid === 1'b1) begin
            res_q.push_back(int'(bus.acc_out));
            res_t.push_back(cyc);
        end
        if (bus_o.acc_valid === 1'b1) o_q.push_back(int'(bus_o.acc_out));
        if (bus_k1.acc_valid === 1'b1) begin
            k1_q.push_back(int'(bus_k1.acc_out));
            k1_t.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        bus.in_valid = v;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.clear    = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic clr_rec();
        res_q.delete();
        res_t.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.a_in = 4'd7; bus.b_in = 4'd7; bus.clear = 1'b0;
        bus_o.in_valid = 1'b1; bus_o.a_in = 4'd7; bus_o.b_in = 4'd7; bus_o.clear = 1'b0;
        bus_k1.in_valid = 1'b1; bus_k1.a_in = 4'd7; bus_k1.b_in = 4'd7; bus_k1.clear = 1'b0;
        step();
        step();
        n_tests += 8;
        if (bus.a_out !== 4'd0) begin n_fail++; $display("FAIL rst_a_out: got %0d expected 0", bus.a_out); end
        if (bus.b_out !== 4'd0) begin n_fail++; $display("FAIL rst_b_out: got %0d expected 0", bus.b_out); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
        if (bus.acc_out !== 16'd0) begin n_fail++; $display("FAIL rst_acc_out: got %0d expected 0", bus.acc_out); end
        if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_acc_valid: got %0b expected 0", bus.acc_valid); end
        if (bus.acc_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_acc_ovf: got %0b expected 0", bus.acc_ovf); end
        if (bus_o.acc_out !== 10'd0) begin n_fail++; $display("FAIL rst_o_acc_out: got %0d expected 0", bus_o.acc_out); end
        if (bus_k1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_k1_out_valid: got %0b expected 0", bus_k1.out_valid); end
        bus_o.in_valid = 1'b0; bus_o.a_in = 4'd0; bus_o.b_in = 4'd0;
        bus_k1.in_valid = 1'b0; bus_k1.a_in = 4'd0; bus_k1.b_in = 4'd0;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_forwarding();
        clr_rec();
        drv(1'b1, 4'd5, 4'd9, 1'b0);
        bus.in_valid = 1'b0; bus.a_in = 4'd3; bus.b_in = 4'd4; bus.clear = 1'b1;
        #1;
        n_tests += 3;
        if (bus.a_out !== 4'd5) begin n_fail++; $display("FAIL fwd_a_out: got %0d expected 5", bus.a_out); end
        if (bus.b_out !== 4'd9) begin n_fail++; $display("FAIL fwd_b_out: got %0d expected 9", bus.b_out); end
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_out_valid: got %0b expected 1", bus.out_valid); end
        step();
        n_tests += 3;
        if (bus.a_out !== 4'd3) begin n_fail++; $display("FAIL fwd_clr_a_out: got %0d expected 3", bus.a_out); end
        if (bus.b_out !== 4'd4) begin n_fail++; $display("FAIL fwd_clr_b_out: got %0d expected 4", bus.b_out); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_clr_out_valid: got %0b expected 0", bus.out_valid); end
        idle(4);
        n_tests++;
        if (res_q.size() != 0) begin n_fail++; $display("FAIL fwd_no_result: got %0d pulses expected 0", res_q.size()); end
    endtask

    task automatic test_full_window();
        int c0;
        clr_rec();
        c0 = cyc;
        for (int i = 0; i < 9; i++) drv(1'b1, 4'd15, 4'd15, 1'b0);
        idle(5);
        n_tests += 4;
        if (res_q.size() != 1) begin n_fail++; $display("FAIL full_pulses: got %0d expected 1", res_q.size()); end
        if (((res_q.size() > 0) ? res_q[0] : -1) != 2025) begin n_fail++; $display("FAIL full_value: got %0d expected 2025", (res_q.size() > 0) ? res_q[0] : -1); end
        if (((res_t.size() > 0) ? res_t[0] - c0 : -1) != 11) begin n_fail++; $display("FAIL full_latency: got cycle %0d expected 11", (res_t.size() > 0) ? res_t[0] - c0 : -1); end
        if (bus.acc_out !== 16'd2025) begin n_fail++; $display("FAIL full_hold: got %0d expected 2025", bus.acc_out); end
    endtask

    task automatic test_bubbles_back_to_back();
        int c0;
        clr_rec();
        c0 = cyc;
        for (int i = 1; i <= 9; i++) begin
            drv(1'b1, 4'(i), 4'(i), 1'b0);
            if (i == 3 || i == 6) drv(1'b0, 4'd15, 4'd15, 1'b0);
        end
        for (int i = 0; i < 9; i++) drv(1'b1, 4'd2, 4'd3, 1'b0);
        idle(5);
        n_tests += 5;
        if (res_q.size() != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", res_q.size()); end
        if (((res_q.size() > 0) ? res_q[0] : -1) != 285) begin n_fail++; $display("FAIL b2b_first: got %0d expected 285", (res_q.size() > 0) ? res_q[0] : -1); end
        if (((res_q.size() > 1) ? res_q[1] : -1) != 54) begin n_fail++; $display("FAIL b2b_second: got %0d expected 54", (res_q.size() > 1) ? res_q[1] : -1); end
        if (((res_t.size() > 0) ? res_t[0] - c0 : -1) != 13) begin n_fail++; $display("FAIL b2b_t1: got cycle %0d expected 13", (res_t.size() > 0) ? res_t[0] - c0 : -1); end
        if (((res_t.size() > 1) ? res_t[1] - c0 : -1) != 22) begin n_fail++; $display("FAIL b2b_t2: got cycle %0d expected 22", (res_t.size() > 1) ? res_t[1] - c0 : -1); end
    endtask

    task automatic test_clear_mid_window();
        int c0;
        clr_rec();
        c0 = cyc;
        for (int i = 0; i < 5; i++) drv(1'b1, 4'd15, 4'd15, 1'b0);
        drv(1'b1, 4'd2, 4'd2, 1'b1);
        for (int i = 0; i < 8; i++) drv(1'b1, 4'd1, 4'd1, 1'b0);
        idle(5);
        n_tests += 3;
        if (res_q.size() != 1) begin n_fail++; $display("FAIL clr_pulses: got %0d expected 1", res_q.size()); end
        if (((res_q.size() > 0) ? res_q[0] : -1) != 12) begin n_fail++; $display("FAIL clr_value: got %0d expected 12", (res_q.size() > 0) ? res_q[0] : -1); end
        if (((res_t.size() > 0) ? res_t[0] - c0 : -1) != 16) begin n_fail++; $display("FAIL clr_latency: got cycle %0d expected 16", (res_t.size() > 0) ? res_t[0] - c0 : -1); end
    endtask

    task automatic test_clear_vs_complete();
        clr_rec();
        for (int i = 0; i < 9; i++) drv(1'b1, 4'd1, 4'd1, 1'b0);
        idle(1);
        drv(1'b0, 4'd0, 4'd0, 1'b1);
        idle(4);
        n_tests += 2;
        if (res_q.size() != 0) begin n_fail++; $display("FAIL clrcmp_pulses: got %0d expected 0", res_q.size()); end
        if (bus.acc_out !== 16'd12) begin n_fail++; $display("FAIL clrcmp_hold: got %0d expected 12", bus.acc_out); end
        for (int i = 0; i < 9; i++) drv(1'b1, 4'd2, 4'd2, 1'b0);
        idle(5);
        n_tests++;
        if (((res_q.size() > 0) ? res_q[0] : -1) != 36) begin n_fail++; $display("FAIL clrcmp_next: got %0d expected 36", (res_q.size() > 0) ? res_q[0] : -1); end
    endtask

    task automatic test_reset_mid_window();
        clr_rec();
        for (int i = 0; i < 4; i++) drv(1'b1, 4'd7, 4'd7, 1'b0);
        rst = 1'b1;
        drv(1'b1, 4'd7, 4'd7, 1'b0);
        rst = 1'b0;
        n_tests += 4;
        if (bus.a_out !== 4'd0) begin n_fail++; $display("FAIL rstmid_a_out: got %0d expected 0", bus.a_out); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %0b expected 0", bus.out_valid); end
        if (bus.acc_out !== 16'd0) begin n_fail++; $display("FAIL rstmid_acc_out: got %0d expected 0", bus.acc_out); end
        if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_acc_valid: got %0b expected 0", bus.acc_valid); end
        for (int i = 0; i < 9; i++) drv(1'b1, 4'd1, 4'd1, 1'b0);
        idle(5);
        n_tests += 2;
        if (res_q.size() != 1) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 1", res_q.size()); end
        if (((res_q.size() > 0) ? res_q[0] : -1) != 9) begin n_fail++; $display("FAIL rstmid_value: got %0d expected 9", (res_q.size() > 0) ? res_q[0] : -1); end
    endtask

    task automatic test_k_len1();
        int c0;
        logic       v_t[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] a_t[4] = '{4'd3, 4'd9, 4'd15, 4'd2};
        logic [3:0] b_t[4] = '{4'd4, 4'd9, 4'd15, 4'd5};
        k1_q.delete();
        k1_t.delete();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            bus_k1.in_valid = v_t[i]; bus_k1.a_in = a_t[i]; bus_k1.b_in = b_t[i];
            step();
        end
        bus_k1.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_tests += 5;
        if (k1_q.size() != 3) begin n_fail++; $display("FAIL k1_pulses: got %0d expected 3", k1_q.size()); end
        if (((k1_q.size() > 0) ? k1_q[0] : -1) != 12) begin n_fail++; $display("FAIL k1_r0: got %0d expected 12", (k1_q.size() > 0) ? k1_q[0] : -1); end
        if (((k1_q.size() > 1) ? k1_q[1] : -1) != 225) begin n_fail++; $display("FAIL k1_r1: got %0d expected 225", (k1_q.size() > 1) ? k1_q[1] : -1); end
        if (((k1_q.size() > 2) ? k1_q[2] : -1) != 10) begin n_fail++; $display("FAIL k1_r2: got %0d expected 10", (k1_q.size() > 2) ? k1_q[2] : -1); end
        if (((k1_t.size() > 0) ? k1_t[0] - c0 : -1) != 3) begin n_fail++; $display("FAIL k1_latency: got cycle %0d expected 3", (k1_t.size() > 0) ? k1_t[0] - c0 : -1); end
    endtask

    task automatic test_overflow();
        int   exp_val;
        logic exp_ovf;
`ifdef PE_SAT_EN
        exp_val = 1023;
        exp_ovf = 1'b1;
`else
        exp_val = 1001;
        exp_ovf = 1'b0;
`endif
        o_q.delete();
        for (int i = 0; i < 9; i++) begin
            bus_o.in_valid = 1'b1; bus_o.a_in = 4'd15; bus_o.b_in = 4'd15;
            step();
        end
        bus_o.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_tests += 3;
        if (o_q.size() != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 1", o_q.size()); end
        if (((o_q.size() > 0) ? o_q[0] : -1) != exp_val) begin n_fail++; $display("FAIL ovf_value: got %0d expected %0d", (o_q.size() > 0) ? o_q[0] : -1, exp_val); end
        if (bus_o.acc_ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag: got %0b expected %0b", bus_o.acc_ovf, exp_ovf); end
        bus_o.clear = 1'b1;
        step();
        bus_o.clear = 1'b0;
        step();
        n_tests++;
        if (bus_o.acc_ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected %0b", bus_o.acc_ovf, exp_ovf); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a_in = 4'd0; bus.b_in = 4'd0; bus.clear = 1'b0;
        bus_o.in_valid = 1'b0; bus_o.a_in = 4'd0; bus_o.b_in = 4'd0; bus_o.clear = 1'b0;
        bus_k1.in_valid = 1'b0; bus_k1.a_in = 4'd0; bus_k1.b_in = 4'd0; bus_k1.clear = 1'b0;
        test_reset();
        test_forwarding();
        test_full_window();
        test_bubbles_back_to_back();
        test_clear_mid_window();
        test_clear_vs_complete();
        test_reset_mid_window();
        test_k_len1();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_pe_mac.md
Name: systolic_pe_mac

Overview:
Systolic-array processing element sitting directly downstream of the 4x4 unsigned vedic multiplier. It registers and forwards operands to neighbouring PEs (a east, b south) and feeds the registered operands into one vedic_multu4 instance. It accumulates K_LEN valid products into one convolution output sample and emits it with a one-cycle valid pulse.

Parameters:
ACC_W, 16, accumulator/result width in bits; must be at least 8.
K_LEN, 9, number of valid products per output sample (3x3 kernel); must be at least 1.

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  a_in/b_in carry a valid sample this cycle
a_in  input  4  unsigned activation operand
b_in  input  4  unsigned weight operand
clear  input  1  start new window; discards partial sum
a_out  output  4  registered a_in, forwarded east
b_out  output  4  registered b_in, forwarded south
out_valid  output  1  registered in_valid, forwarded with a_out/b_out
acc_out  output  ACC_W  completed window sum; holds until next result
acc_valid  output  1  one-cycle pulse when acc_out updates
acc_ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): a_out=0, b_out=0, out_valid=0, acc_out=0, acc_valid=0, acc_ovf=0; internal accumulator, count and all stage valids = 0. rst overrides clear and in_valid. Reset mid-window drops the partial sum and all in-flight samples.
- Stage 0 (every cycle): a_q<=a_in, b_q<=b_in, v_q<=in_valid, m_v<=in_valid. a_out/b_out/out_valid = a_q/b_q/v_q. Forwarding latency is 1 cycle. Operands update even when in_valid=0. clear never affects forwarding.
- Stage 1: p = vedic_multu4(a_q, b_q), 8 bits, range 0..225. p_q<=p; pv_q<=m_v & ~clear.
- Stage 2: if pv_q and count<K_LEN-1, then acc<=acc+zext(p_q) and count++. If pv_q and count==K_LEN-1, then acc_out<=acc+zext(p_q), acc_valid<=1, acc<=0, count<=0. Otherwise acc_valid<=0.
- Latency: last sample at in_valid in cycle t gives acc_valid=1 in cycle t+3. Back-to-back windows need no idle cycles. Gaps in in_valid are bubbles and do not advance count.
- K_LEN=1: every valid product produces a result.
- clear in cycle t: acc<=0 and count<=0. The sample held in stage 0 (accepted at t-1) and the sample in pv_q are discarded. An in_valid sample presented in cycle t is kept as the first sample of the new window. acc_out keeps its last value. No acc_valid pulse is generated for the discarded partial. Because clear discards the in-flight samples, it takes precedence over a window completion in the same cycle: no result is emitted.
- Arithmetic: unsigned. Default mode: sum wraps modulo 2^ACC_W and acc_ovf stays 0.

Optional Feature:
PE_SAT_EN. When defined, each accumulate step (including the final one) clamps at 2^ACC_W-1 instead of wrapping. acc_ovf is set on the first clamp and stays set until rst; clear does not reset it. When not defined, the sum wraps as described and acc_ovf is tied to 0. The port exists in both builds.

Test Plan:
- Forwarding: in_valid=1, a_in=5, b_in=9 at cycle 0 -> a_out=5, b_out=9, out_valid=1 at cycle 1; clear=1 in that cycle has no effect on these outputs.
- Full window, K_LEN=9: nine consecutive samples a=15, b=15 starting cycle 0 -> acc_valid pulse at cycle 11 with acc_out=2025; acc_valid=0 at cycles 10 and 12.
- Bubbles and back-to-back: samples 1x1..9x9 (a=b=i, i=1..9) with in_valid=0 gaps after i=3 and i=6, then immediately nine 2x3 samples -> acc_out=285 (1^2+...+9^2), then acc_out=54, each a single pulse.
- Clear mid-window: five 15x15 samples, clear asserted with a 2x2 sample, then eight more 1x1 samples -> acc_out=12 (4+8); no pulse for the discarded partial.
- Reset mid-window: four 7x7 samples, rst=1 for one cycle -> all outputs 0 next cycle; a following nine 1x1 window gives acc_out=9.
- Overflow, ACC_W=10: nine 15x15 samples -> default build gives acc_out=1001 (2025 mod 1024), acc_ovf=0; PE_SAT_EN build gives acc_out=1023, acc_ovf=1, and acc_ovf stays 1 after a subsequent clear.
